disp_share_arbiter: RTL and testbench

Time-shares the 4-digit seven-segment display between NREQ debug requesters (PC, register file, ALU result, bus address, ...). Each requester presents a 16-bit value and a request. A round-robin arbiter grants the display for a fixed dwell period, then moves to the next requester. The registered hex output drives the hex input of the display digit driver.

---
 rtl/disp_share_arbiter.sv | 137 +++++++++++++
 tb/tb_disp_share_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/disp_share_arbiter.sv
// rtl/disp_share_arbiter.sv - round-robin time-share of the hex display between NREQ requesters
// Optional requester-0 preemption is enabled by defining DISP_ARB_PREEMPT_EN.
module disp_share_arbiter #(
    parameter int          NREQ         = 4,
    parameter int          DWELL_CYCLES = 100000000,
    parameter logic [15:0] IDLE_VALUE   = 16'h0000,
    localparam int         IDXW         = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   data,
    input  logic                 lock,
    output logic [15:0]          hex,
    output logic                 hex_valid,
    output logic [NREQ-1:0]      grant,
    output logic [IDXW-1:0]      owner,
    output logic [NREQ-1:0]      done
);

    localparam int CW = $clog2(DWELL_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t             state_q;
    logic [IDXW-1:0]    ptr_q;
    logic [IDXW-1:0]    owner_q;
    logic [CW-1:0]      cnt_q;
    logic [15:0]        hex_q;
    logic               valid_q;
    logic [NREQ-1:0]    grant_q;
    logic [NREQ-1:0]    done_q;

    logic               win_found_d;
    logic [IDXW-1:0]    win_idx_d;
    logic               expire;
    logic               drop;
    logic               preempt;

    // Scan downward so the last hit kept is the one closest after the pointer;
    // the pointer itself (current owner) is therefore considered last.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            int s;
            logic [IDXW-1:0] cand;
            s = int'(ptr_q) + i;
            if (s >= NREQ) begin
                s = s - NREQ;
            end
            cand = IDXW'(s);
            if (req[cand]) begin
                win_found_d = 1'b1;
                win_idx_d   = cand;
            end
        end
    end

    assign expire = (cnt_q == CW'(DWELL_CYCLES - 1)) && !lock;
    assign drop   = !req[owner_q];

`ifdef DISP_ARB_PREEMPT_EN
    assign preempt = req[0] && (owner_q != '0);
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= IDXW'(NREQ - 1);
            owner_q <= '0;
            cnt_q   <= '0;
            hex_q   <= IDLE_VALUE;
            valid_q <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (win_found_d) begin
                        state_q <= ST_SHOW;
                        ptr_q   <= win_idx_d;
                        owner_q <= win_idx_d;
                        grant_q <= NREQ'(1) << win_idx_d;
                        hex_q   <= data[{win_idx_d, 4'b0000} +: 16];
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_SHOW: begin
                    hex_q <= data[{owner_q, 4'b0000} +: 16];
                    if (preempt) begin
                        ptr_q   <= '0;
                        owner_q <= '0;
                        grant_q <= NREQ'(1);
                        hex_q   <= data[15:0];
                        cnt_q   <= '0;
                    end else if (expire || drop) begin
                        if (!drop) begin
                            done_q <= grant_q;
                        end
                        if (win_found_d) begin
                            ptr_q   <= win_idx_d;
                            owner_q <= win_idx_d;
                            grant_q <= NREQ'(1) << win_idx_d;
                            hex_q   <= data[{win_idx_d, 4'b0000} +: 16];
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                            owner_q <= '0;
                            grant_q <= '0;
                            hex_q   <= IDLE_VALUE;
                            valid_q <= 1'b0;
                            cnt_q   <= '0;
                        end
                    end else if (!lock) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign hex       = hex_q;
    assign hex_valid = valid_q;
    assign grant     = grant_q;
    assign owner     = owner_q;
    assign done      = done_q;

endmodule

// File: tb/tb_disp_share_arbiter.sv
// tb/tb_disp_share_arbiter.sv - directed self-checking bench for disp_share_arbiter
module tb_disp_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] data;
    logic        lock;
    logic [15:0] hex;
    logic        hex_valid;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic [3:0]  done;

    int total = 0;
    int bad   = 0;

    disp_share_arbiter #(
        .NREQ(4),
        .DWELL_CYCLES(4),
        .IDLE_VALUE(16'hDEAD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .data(data),
        .lock(lock),
        .hex(hex),
        .hex_valid(hex_valid),
        .grant(grant),
        .owner(owner),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later; invariants checked every step.
    task automatic step();
        logic [3:0] g;
        @(posedge clk);
        #1;
        g = grant;
        chk("grant_onehot0", 32'((g & (g - 4'd1)) == 4'd0), 32'd1);
        chk("valid_vs_grant", 32'(hex_valid), 32'(g != 4'd0));
    endtask

    task automatic chk_state(input string tag, input logic [3:0] eg, input logic [3:0] ed,
                             input logic [15:0] eh);
        chk({tag, "_grant"}, 32'(grant), 32'(eg));
        chk({tag, "_done"}, 32'(done), 32'(ed));
        chk({tag, "_hex"}, 32'(hex), 32'(eh));
    endtask

    initial begin
        reset = 1'b0;
        lock  = 1'b0;
        req   = 4'b1111;
        data  = {16'h3333, 16'h2222, 16'h1111, 16'h1000};

        // reset held with all requests up
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("reset", 4'b0000, 4'b0000, 16'hDEAD);
            chk("reset_valid", 32'(hex_valid), 32'd0);
        end
        chk("reset_owner", 32'(owner), 32'd0);

        reset = 1'b1;
        step();
        chk_state("first", 4'b0001, 4'b0000, 16'h1000);
        chk("first_valid", 32'(hex_valid), 32'd1);

        // rotation between 1 and 3; dropping req0 hands over with no done
        req = 4'b1010;
        step();
        chk_state("drop0", 4'b0010, 4'b0000, 16'h1111);
        chk("drop0_owner", 32'(owner), 32'd1);
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                step();
                chk_state("rot_hold1", 4'b0010, 4'b0000, 16'h1111);
            end
            step();
            chk_state("rot_to3", 4'b1000, 4'b0010, 16'h3333);
            chk("rot_owner3", 32'(owner), 32'd3);
            for (int j = 0; j < 3; j++) begin
                step();
                chk_state("rot_hold3", 4'b1000, 4'b0000, 16'h3333);
            end
            step();
            chk_state("rot_to1", 4'b0010, 4'b1000, 16'h1111);
        end

        // sole requester re-granted, then drop at count 1
        req = 4'b0100;
        step();
        chk_state("sole_take", 4'b0100, 4'b0000, 16'h2222);
        for (int j = 0; j < 3; j++) begin
            step();
            chk_state("sole_hold", 4'b0100, 4'b0000, 16'h2222);
        end
        step();
        chk_state("sole_regrant", 4'b0100, 4'b0100, 16'h2222);
        step();
        req = 4'b0000;
        step();
        chk_state("sole_drop", 4'b0000, 4'b0000, 16'hDEAD);
        chk("sole_drop_owner", 32'(owner), 32'd0);
        step();
        chk_state("idle_hold", 4'b0000, 4'b0000, 16'hDEAD);

        // lock keeps owner 1 despite other requests
        req = 4'b0010;
        step();
        chk_state("lock_take", 4'b0010, 4'b0000, 16'h1111);
        req  = 4'b1110;
        lock = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step();
            chk_state("locked", 4'b0010, 4'b0000, 16'h1111);
        end
        lock = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk_state("unlock_hold", 4'b0010, 4'b0000, 16'h1111);
        end
        step();
        chk_state("unlock_exp", 4'b0100, 4'b0010, 16'h2222);

        // live data of owner 3
        req = 4'b1000;
        data[63:48] = 16'hAAAA;
        step();
        chk_state("live_take", 4'b1000, 4'b0000, 16'hAAAA);
        data[63:48] = 16'h5555;
        #1;
        chk("live_before", 32'(hex), 32'h0000AAAA);
        step();
        chk("live_after", 32'(hex), 32'h00005555);

        // requester 0 arrives while owner 2 is at count 1
        req = 4'b0100;
        step();
        chk_state("pre_take2", 4'b0100, 4'b0000, 16'h2222);
        step();
        req = 4'b1101;
`ifdef DISP_ARB_PREEMPT_EN
        step();
        chk_state("preempt", 4'b0001, 4'b0000, 16'h1000);
        chk("preempt_owner", 32'(owner), 32'd0);
`else
        step();
        chk_state("nopre_c2", 4'b0100, 4'b0000, 16'h2222);
        step();
        chk_state("nopre_c3", 4'b0100, 4'b0000, 16'h2222);
        step();
        chk_state("nopre_exp", 4'b1000, 4'b0100, 16'h5555);
        chk("nopre_owner", 32'(owner), 32'd3);
`endif

        // reset mid-tenure
        step();
        reset = 1'b0;
        step();
        chk_state("mid_reset", 4'b0000, 4'b0000, 16'hDEAD);
        chk("mid_reset_owner", 32'(owner), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
